// File: rtl/water_release_scheduler.sv
// Two-requester (city/town) reservoir release scheduler: arbitrates, meters RATE units per
// cycle through one valve and stops at the RESERVE floor. Optional: STARVATION_GUARD_EN.
module water_release_scheduler #(
   parameter int LEVEL_W   = 10,
   parameter int VOL_W     = 8,
   parameter int RATE      = 4,
   parameter int RESERVE   = 50,
   parameter int LOW_LEVEL = 200
`ifdef STARVATION_GUARD_EN
   ,
   parameter int STARVE_LIMIT = 3
`endif
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [LEVEL_W-1:0] reservoir_level,
   input  logic               city_req,
   input  logic [VOL_W-1:0]   city_vol,
   input  logic               town_req,
   input  logic [VOL_W-1:0]   town_vol,
   output logic               city_grant,
   output logic               town_grant,
   output logic               valve_open,
   output logic [VOL_W-1:0]   drain_amt,
   output logic               city_done,
   output logic               town_done,
   output logic               short_delivery,
   output logic               busy,
   output logic               ration
);

   localparam int CMP_W = (LEVEL_W > VOL_W) ? LEVEL_W : VOL_W;
   localparam logic [LEVEL_W-1:0] RESERVE_L = LEVEL_W'(RESERVE);
   localparam logic [LEVEL_W-1:0] LOW_L     = LEVEL_W'(LOW_LEVEL);
   localparam logic [VOL_W-1:0]   RATE_V    = VOL_W'(RATE);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE, S_DONE} state_e;
   typedef enum logic {CITY = 1'b0, TOWN = 1'b1} who_e;

   state_e             state_q, state_d;
   who_e               owner_q, owner_d;
   who_e               last_q, last_d;
   logic [VOL_W-1:0]   remaining_q, remaining_d;
   logic               short_q, short_d;
   logic               ration_q, ration_d;

   logic [LEVEL_W-1:0] headroom;
   logic [VOL_W-1:0]   cap;
   logic [VOL_W-1:0]   amt;
   logic [VOL_W-1:0]   grant_vol;
   logic               level_ok;
   logic               city_wins;

`ifdef STARVATION_GUARD_EN
   localparam logic [1:0] STARVE_L = 2'(STARVE_LIMIT);
   logic [1:0] starve_cnt_q, starve_cnt_d;

   // Counts city grants that made a waiting town sit out under rationing.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!ration_q) begin
         starve_cnt_d = '0;
      end else if (state_q == S_GRANT) begin
         if (owner_q == TOWN) begin
            starve_cnt_d = '0;
         end else if (town_req && starve_cnt_q != 2'b11) begin
            starve_cnt_d = starve_cnt_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) starve_cnt_q <= '0;
      else        starve_cnt_q <= starve_cnt_d;
   end
`endif

   // NOTE: every signal gets its default first so no path through the block infers a latch.
   always_comb begin
      headroom = '0;
      if (reservoir_level > RESERVE_L) headroom = reservoir_level - RESERVE_L;
      cap = (remaining_q < RATE_V) ? remaining_q : RATE_V;
      amt = cap;
      if (CMP_W'(headroom) < CMP_W'(cap)) amt = VOL_W'(headroom);
      level_ok  = (reservoir_level > RESERVE_L);
      grant_vol = (owner_q == CITY) ? city_vol : town_vol;
      ration_d  = (reservoir_level <= LOW_L);
   end

   always_comb begin
      city_wins = 1'b0;
      if (city_req && !town_req) begin
         city_wins = 1'b1;
      end else if (city_req && town_req) begin
         city_wins = ration_q ? 1'b1 : (last_q == TOWN);
`ifdef STARVATION_GUARD_EN
         if (starve_cnt_q == STARVE_L) city_wins = 1'b0;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      remaining_d = remaining_q;
      short_d     = short_q;
      case (state_q)
         S_IDLE: begin
            if ((city_req || town_req) && level_ok) begin
               owner_d = city_wins ? CITY : TOWN;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            remaining_d = grant_vol;
            last_d      = owner_q;
            short_d     = 1'b0;
            state_d     = (grant_vol == '0) ? S_DONE : S_RELEASE;
         end
         S_RELEASE: begin
            remaining_d = remaining_q - amt;
            if (remaining_q == amt) begin
               short_d = 1'b0;
               state_d = S_DONE;
            end else if (amt < cap) begin
               // Reserve floor limited this cycle: abandon the rest of the volume.
               short_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         owner_q     <= CITY;
         last_q      <= TOWN;
         remaining_q <= '0;
         short_q     <= 1'b0;
         ration_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         remaining_q <= remaining_d;
         short_q     <= short_d;
         ration_q    <= ration_d;
      end
   end

   always_comb begin
      busy           = (state_q != S_IDLE);
      city_grant     = busy && (owner_q == CITY);
      town_grant     = busy && (owner_q == TOWN);
      valve_open     = (state_q == S_RELEASE);
      drain_amt      = valve_open ? amt : '0;
      city_done      = (state_q == S_DONE) && (owner_q == CITY);
      town_done      = (state_q == S_DONE) && (owner_q == TOWN);
      short_delivery = (state_q == S_DONE) && short_q;
      ration         = ration_q;
   end

endmodule

// File: tb/tb_water_release_scheduler.sv
// Self-checking bench for water_release_scheduler: vector table, directed corner sequences,
// and randomized transactions against a transaction-level reference model.
module tb_water_release_scheduler;

   localparam int RATE      = 4;
   localparam int RESERVE   = 50;
   localparam int LOW_LEVEL = 200;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [9:0] reservoir_level = '0;
   logic       city_req = 1'b0;
   logic [7:0] city_vol = '0;
   logic       town_req = 1'b0;
   logic [7:0] town_vol = '0;
   logic       city_grant, town_grant, valve_open, city_done, town_done;
   logic       short_delivery, busy, ration;
   logic [7:0] drain_amt;

   always #5 clk = ~clk;

   water_release_scheduler dut (
      .clk(clk), .reset(reset), .reservoir_level(reservoir_level),
      .city_req(city_req), .city_vol(city_vol), .town_req(town_req), .town_vol(town_vol),
      .city_grant(city_grant), .town_grant(town_grant), .valve_open(valve_open),
      .drain_amt(drain_amt), .city_done(city_done), .town_done(town_done),
      .short_delivery(short_delivery), .busy(busy), .ration(ration)
   );

   typedef struct packed {
      logic       cg;
      logic       tg;
      logic       valve;
      logic [7:0] drain;
      logic       cd;
      logic       td;
      logic       sh;
      logic       busy;
   } exp_t;

   typedef struct {
      logic       creq;
      logic [7:0] cvol;
      logic       treq;
      logic [7:0] tvol;
      logic [9:0] lvl;
      exp_t       exp;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   int   win_log[$];
   bit   last_town_m = 1'b1;
   bit   ration_m = 1'b0;
   int   starve_m = 0;
   bit   tank_en = 1'b0;
   bit   prev_busy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   function automatic exp_t mk(bit cg, bit tg, bit v, int d, bit cd, bit td, bit sh, bit b);
      exp_t e;
      e.cg = cg; e.tg = tg; e.valve = v; e.drain = 8'(d);
      e.cd = cd; e.td = td; e.sh = sh; e.busy = b;
      return e;
   endfunction

   function automatic exp_t dut_outs();
      return exp_t'({city_grant, town_grant, valve_open, drain_amt,
                     city_done, town_done, short_delivery, busy});
   endfunction

   // Expands one granted transaction into its per-cycle expected outputs.
   function automatic void build(bit t, int vol, int lvl);
      exp_t g, r, d;
      int   rem, h, cap, amt;
      bit   sh;
      rem = vol;
      sh  = 1'b0;
      g   = mk(!t, t, 0, 0, 0, 0, 0, 1);
      exp_q.push_back(g);
      while (rem > 0) begin
         h   = (lvl > RESERVE) ? lvl - RESERVE : 0;
         cap = (rem < RATE) ? rem : RATE;
         amt = (h < cap) ? h : cap;
         r = g;
         r.valve = 1'b1;
         r.drain = 8'(amt);
         exp_q.push_back(r);
         rem = rem - amt;
         if (tank_en) lvl = lvl - amt;
         if (amt < cap) begin
            sh = 1'b1;
            break;
         end
      end
      d = g;
      d.cd = !t;
      d.td = t;
      d.sh = sh;
      exp_q.push_back(d);
   endfunction

   // One clock of model-checked operation; returns at posedge+1 ready for new inputs.
   task automatic tick();
      exp_t e, a;
      bit   was_idle, win_town, granted;
      @(negedge clk);
      cyc++;
      a = dut_outs();
      if (busy && !prev_busy) win_log.push_back(town_grant ? 1 : 0);
      prev_busy = busy;
      was_idle = (exp_q.size() == 0);
      e = '0;
      if (!was_idle) e = exp_q.pop_front();
      check($sformatf("cycle %0d outputs", cyc), 32'(a), 32'(e));
      check($sformatf("cycle %0d ration", cyc), 32'(ration), 32'(ration_m));
      granted  = 1'b0;
      win_town = 1'b0;
      if (was_idle && (city_req || town_req) && int'(reservoir_level) > RESERVE) begin
         if (city_req && town_req) begin
            win_town = ration_m ? 1'b0 : !last_town_m;
`ifdef STARVATION_GUARD_EN
            if (starve_m == 3) win_town = 1'b1;
`endif
         end else begin
            win_town = town_req;
         end
         build(win_town, win_town ? int'(town_vol) : int'(city_vol), int'(reservoir_level));
         last_town_m = win_town;
         granted = 1'b1;
      end
`ifdef STARVATION_GUARD_EN
      if (!ration_m) starve_m = 0;
      if (granted) begin
         if (!(int'(reservoir_level) <= LOW_LEVEL) || win_town) starve_m = 0;
         else if (town_req && starve_m < 3) starve_m++;
      end
`endif
      ration_m = (int'(reservoir_level) <= LOW_LEVEL);
      @(posedge clk);
      #1;
      if (tank_en) reservoir_level = reservoir_level - 10'(e.drain);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("in-reset outputs %0d", i), 32'(dut_outs()), 32'd0);
         check($sformatf("in-reset ration %0d", i), 32'(ration), 32'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      last_town_m = 1'b1;
      ration_m = 1'b0;
      starve_m = 0;
      prev_busy = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      check({name, " idle timeout"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_grants(input string name, input int n);
      for (int i = 0; i < 200; i++) begin
         if (win_log.size() >= n) break;
         tick();
      end
      check({name, " grant timeout"}, 32'(win_log.size() >= n), 32'd1);
   endtask

   initial begin : watchdog
      #800000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vec_t tbl[$];
      int   rat_exp[5];
      bit   seen;

      // city 10 @500: 4,4,2 then done, no short
      tbl.push_back('{1, 10, 0, 0, 500, mk(0,0,0,0,0,0,0,0)});
      tbl.push_back('{1, 10, 0, 0, 500, mk(1,0,0,0,0,0,0,1)});
      tbl.push_back('{1, 10, 0, 0, 500, mk(1,0,1,4,0,0,0,1)});
      tbl.push_back('{1, 10, 0, 0, 500, mk(1,0,1,4,0,0,0,1)});
      tbl.push_back('{1, 10, 0, 0, 500, mk(1,0,1,2,0,0,0,1)});
      tbl.push_back('{1, 10, 0, 0, 500, mk(1,0,0,0,1,0,0,1)});
      tbl.push_back('{0, 10, 0, 0, 500, mk(0,0,0,0,0,0,0,0)});
      // town 20 @57 with the level falling by each drain: 4, 3, short
      tbl.push_back('{0, 0, 1, 20, 57, mk(0,0,0,0,0,0,0,0)});
      tbl.push_back('{0, 0, 1, 20, 57, mk(0,1,0,0,0,0,0,1)});
      tbl.push_back('{0, 0, 1, 20, 57, mk(0,1,1,4,0,0,0,1)});
      tbl.push_back('{0, 0, 1, 20, 53, mk(0,1,1,3,0,0,0,1)});
      tbl.push_back('{0, 0, 1, 20, 50, mk(0,1,0,0,0,1,1,1)});
      tbl.push_back('{0, 0, 0, 20, 50, mk(0,0,0,0,0,0,0,0)});
      // request at the reserve floor is not served
      tbl.push_back('{0, 0, 1, 20, 50, mk(0,0,0,0,0,0,0,0)});
      tbl.push_back('{0, 0, 1, 20, 50, mk(0,0,0,0,0,0,0,0)});
      tbl.push_back('{0, 0, 0, 20, 50, mk(0,0,0,0,0,0,0,0)});
      // zero volume: grant then straight to done
      tbl.push_back('{1, 0, 0, 0, 500, mk(0,0,0,0,0,0,0,0)});
      tbl.push_back('{1, 0, 0, 0, 500, mk(1,0,0,0,0,0,0,1)});
      tbl.push_back('{1, 0, 0, 0, 500, mk(1,0,0,0,1,0,0,1)});
      tbl.push_back('{0, 0, 0, 0, 500, mk(0,0,0,0,0,0,0,0)});

      // reset dominates active requests and a low level
      city_req = 1'b1; town_req = 1'b1; reservoir_level = 10'd150;
      do_reset();
      city_req = 1'b0; town_req = 1'b0; reservoir_level = 10'd500;

      for (int i = 0; i < tbl.size(); i++) begin
         city_req = tbl[i].creq; city_vol = tbl[i].cvol;
         town_req = tbl[i].treq; town_vol = tbl[i].tvol;
         reservoir_level = tbl[i].lvl;
         @(negedge clk);
         check($sformatf("vector %0d", i), 32'(dut_outs()), 32'(tbl[i].exp));
         @(posedge clk);
         #1;
      end

      // model-checked from here on
      city_req = 1'b0; town_req = 1'b0; reservoir_level = 10'd500;
      do_reset();
      repeat (2) tick();

      // round robin with both held, first tie to city
      city_vol = 8'd8; town_vol = 8'd8; city_req = 1'b1; town_req = 1'b1;
      win_log.delete();
      wait_grants("round robin", 3);
      if (win_log.size() >= 3) begin
         check("rr grant 0", 32'(win_log[0]), 32'd0);
         check("rr grant 1", 32'(win_log[1]), 32'd1);
         check("rr grant 2", 32'(win_log[2]), 32'd0);
      end
      city_req = 1'b0; town_req = 1'b0;
      wait_idle("round robin");

      // rationing: city priority, town forced only with the starvation guard
      reservoir_level = 10'd150;
      repeat (2) tick();
      city_vol = 8'd4; town_vol = 8'd4; city_req = 1'b1; town_req = 1'b1;
      win_log.delete();
      wait_grants("ration", 5);
`ifdef STARVATION_GUARD_EN
      rat_exp = '{0, 0, 0, 1, 0};
`else
      rat_exp = '{0, 0, 0, 0, 0};
`endif
      if (win_log.size() >= 5)
         for (int i = 0; i < 5; i++)
            check($sformatf("ration grant %0d", i), 32'(win_log[i]), 32'(rat_exp[i]));
      city_req = 1'b0; town_req = 1'b0;
      wait_idle("ration");

      // reset mid-release: valve shuts at once, no done pulse
      reservoir_level = 10'd500; city_vol = 8'd40; city_req = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (valve_open) begin
            seen = 1'b1;
            break;
         end
      end
      check("mid reset reached release", 32'(seen), 32'd1);
      reset = 1'b0;
      #1;
      check("mid reset valve", 32'(valve_open), 32'd0);
      check("mid reset drain", 32'(drain_amt), 32'd0);
      check("mid reset done", 32'({city_done, town_done}), 32'd0);
      city_req = 1'b0;
      do_reset();
      repeat (2) tick();

      // randomized transactions
      for (int n = 0; n < 250; n++) begin
         wait_idle("random");
         city_req = ($urandom_range(0, 3) != 0);
         town_req = ($urandom_range(0, 3) != 0);
         city_vol = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 120)) : 8'($urandom_range(0, 30));
         town_vol = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 120)) : 8'($urandom_range(0, 30));
         tank_en  = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 3))
            0: reservoir_level = 10'($urandom_range(0, 1023));
            1: reservoir_level = 10'($urandom_range(40, 70));
            2: reservoir_level = 10'($urandom_range(180, 220));
            default: reservoir_level = 10'd500;
         endcase
         tick();
      end
      wait_idle("random end");
      tank_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
